// File: rtl/skid_buffer_pipe.sv
// Valid/ready skid buffer between a producer and a consumer: bypass (REG_OUT=0) or fully
// registered (REG_OUT=1) output, with synchronous flush, occupancy and a saturating stall counter.
module skid_buffer_pipe #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned REG_OUT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              i_valid_i,
  input  logic [DATA_W-1:0] i_data_i,
  output logic              i_ready_o,
  output logic              e_valid_o,
  output logic [DATA_W-1:0] e_data_o,
  input  logic              e_ready_i,
  output logic [1:0]        count_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [CNT_W-1:0] STALL_MAX = '1;

  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_in_xfer;
  logic              w_stall;

  assign i_ready_o = ~r_skid_valid;
  assign w_in_xfer = i_valid_i & ~r_skid_valid;
  assign w_stall   = e_valid_o & ~e_ready_i;

  generate
    if (REG_OUT == 0) begin : g_bypass
      // Skid catches a word only when the consumer refuses it in the cycle it arrives.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_skid_valid <= 1'b0;
          r_skid_data  <= '0;
        end else if (flush_i || e_ready_i) begin
          r_skid_valid <= 1'b0;
        end else if (w_in_xfer) begin
          r_skid_valid <= 1'b1;
          r_skid_data  <= i_data_i;
        end
      end

      assign e_valid_o = r_skid_valid | i_valid_i;
      assign e_data_o  = r_skid_valid ? r_skid_data : i_data_i;
      assign count_o   = {1'b0, r_skid_valid};
    end else begin : g_reg
      logic              r_out_valid;
      logic [DATA_W-1:0] r_out_data;
      logic              w_out_load;

      assign w_out_load = ~r_out_valid | e_ready_i;

      // Output register refills from the skid first so words keep arrival order.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_out_valid  <= 1'b0;
          r_out_data   <= '0;
          r_skid_valid <= 1'b0;
          r_skid_data  <= '0;
        end else if (flush_i) begin
          r_out_valid  <= 1'b0;
          r_skid_valid <= 1'b0;
        end else if (w_out_load) begin
          if (r_skid_valid) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= r_skid_data;
            r_skid_valid <= 1'b0;
          end else if (w_in_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= i_data_i;
          end else begin
            r_out_valid <= 1'b0;
          end
        end else if (w_in_xfer) begin
          r_skid_valid <= 1'b1;
          r_skid_data  <= i_data_i;
        end
      end

      assign e_valid_o = r_out_valid;
      assign e_data_o  = r_out_data;
      assign count_o   = {1'b0, r_out_valid} + {1'b0, r_skid_valid};
    end
  endgenerate

  // Stall counter survives flush; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != STALL_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_skid_buffer_pipe.sv
// Bench for skid_buffer_pipe: registered, bypass and 3-bit-counter instances share one stimulus.
module tb_skid_buffer_pipe;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fl = 1'b0;
  logic       iv = 1'b0;
  logic [7:0] idata = 8'd0;
  logic       er = 1'b0;

  logic       rdy_a, rdy_b, rdy_c, ev_a, ev_b, ev_c;
  logic [7:0] ed_a, ed_b, ed_c;
  logic [1:0] cnt_a, cnt_b, cnt_c;
  logic [15:0] stl_a, stl_b;
  logic [2:0]  stl_c;

  logic        rdy[3], ev[3];
  logic [7:0]  ed[3];
  logic [1:0]  cnt[3];
  logic [15:0] stl[3];

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: per-instance ordered word list plus stall count
  logic [7:0] mq[3][3];
  int         mn[3];
  int         st[3];

  always #5 clk = ~clk;

  skid_buffer_pipe #(.DATA_W(8), .REG_OUT(1), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .flush_i(fl), .i_valid_i(iv), .i_data_i(idata),
    .i_ready_o(rdy_a), .e_valid_o(ev_a), .e_data_o(ed_a), .e_ready_i(er),
    .count_o(cnt_a), .stall_cnt_o(stl_a));

  skid_buffer_pipe #(.DATA_W(8), .REG_OUT(0), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .flush_i(fl), .i_valid_i(iv), .i_data_i(idata),
    .i_ready_o(rdy_b), .e_valid_o(ev_b), .e_data_o(ed_b), .e_ready_i(er),
    .count_o(cnt_b), .stall_cnt_o(stl_b));

  skid_buffer_pipe #(.DATA_W(8), .REG_OUT(1), .CNT_W(3)) u_c (
    .clk(clk), .reset(reset), .flush_i(fl), .i_valid_i(iv), .i_data_i(idata),
    .i_ready_o(rdy_c), .e_valid_o(ev_c), .e_data_o(ed_c), .e_ready_i(er),
    .count_o(cnt_c), .stall_cnt_o(stl_c));

  always_comb begin
    rdy[0] = rdy_a; rdy[1] = rdy_b; rdy[2] = rdy_c;
    ev[0]  = ev_a;  ev[1]  = ev_b;  ev[2]  = ev_c;
    ed[0]  = ed_a;  ed[1]  = ed_b;  ed[2]  = ed_c;
    cnt[0] = cnt_a; cnt[1] = cnt_b; cnt[2] = cnt_c;
    stl[0] = stl_a; stl[1] = stl_b; stl[2] = 16'(stl_c);
  end

  typedef struct {
    logic fl, iv; logic [7:0] d; logic er;
    logic xr, xv; logic [7:0] xd; logic [1:0] xc; logic [15:0] xs;
  } vec_t;
  vec_t tbl[13];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; fl = 1'b0; iv = 1'b0; idata = 8'd0; er = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin mn[k] = 0; st[k] = 0; end
  endtask

  // Compare one instance with the model for the current cycle, then advance the model.
  task automatic model_step(input int k);
    bit reg_out = (k != 1);
    int cap = (k == 2) ? 7 : 65535;
    bit x_rdy, x_val, in_x, out_x;
    logic [7:0] x_dat;
    x_rdy = reg_out ? (mn[k] < 2) : (mn[k] == 0);
    x_val = (mn[k] > 0) || (!reg_out && iv);
    x_dat = (mn[k] > 0) ? mq[k][0] : idata;
    check($sformatf("rnd%0d_ready", k), int'(rdy[k]), int'(x_rdy));
    check($sformatf("rnd%0d_valid", k), int'(ev[k]), int'(x_val));
    if (x_val) check($sformatf("rnd%0d_data", k), int'(ed[k]), int'(x_dat));
    check($sformatf("rnd%0d_count", k), int'(cnt[k]), mn[k]);
    check($sformatf("rnd%0d_stall", k), int'(stl[k]), st[k]);
    in_x  = iv && x_rdy;
    out_x = x_val && er;
    if (in_x) begin mq[k][mn[k]] = idata; mn[k]++; end
    if (out_x) begin
      for (int j = 0; j < 2; j++) mq[k][j] = mq[k][j+1];
      mn[k]--;
    end
    if (fl) mn[k] = 0;
    if (x_val && !er && st[k] < cap) st[k]++;
  endtask

  initial begin
    int xfers;
    tbl[0]  = '{0, 1,  90, 0,  1, 0,   0, 0, 0};
    tbl[1]  = '{0, 1, 255, 0,  1, 1,  90, 1, 0};
    tbl[2]  = '{0, 0,   0, 0,  0, 1,  90, 2, 1};
    tbl[3]  = '{0, 0,   0, 1,  0, 1,  90, 2, 2};
    tbl[4]  = '{0, 0,   0, 1,  1, 1, 255, 1, 2};
    tbl[5]  = '{0, 0,   0, 1,  1, 0,   0, 0, 2};
    tbl[6]  = '{0, 1,  11, 0,  1, 0,   0, 0, 2};
    tbl[7]  = '{0, 1,  22, 0,  1, 1,  11, 1, 2};
    tbl[8]  = '{1, 1,  77, 0,  0, 1,  11, 2, 3};
    tbl[9]  = '{0, 0,   0, 1,  1, 0,   0, 0, 4};
    tbl[10] = '{0, 1,  33, 1,  1, 0,   0, 0, 4};
    tbl[11] = '{0, 0,   0, 1,  1, 1,  33, 1, 4};
    tbl[12] = '{0, 0,   0, 1,  1, 0,   0, 0, 4};

    // Reset values while reset is held low
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst%0d_ready", k), int'(rdy[k]), 1);
      check($sformatf("rst%0d_valid", k), int'(ev[k]), 0);
      check($sformatf("rst%0d_count", k), int'(cnt[k]), 0);
      check($sformatf("rst%0d_stall", k), int'(stl[k]), 0);
    end
    check("rst_data", int'(ed[0]), 0);
    do_reset();

    // Registered instance: fill, drain, flush with a word offered
    for (int i = 0; i < 13; i++) begin
      fl = tbl[i].fl; iv = tbl[i].iv; idata = tbl[i].d; er = tbl[i].er;
      #1;
      check($sformatf("vec%0d_ready", i), int'(rdy[0]), int'(tbl[i].xr));
      check($sformatf("vec%0d_valid", i), int'(ev[0]), int'(tbl[i].xv));
      if (tbl[i].xv) check($sformatf("vec%0d_data", i), int'(ed[0]), int'(tbl[i].xd));
      check($sformatf("vec%0d_count", i), int'(cnt[0]), int'(tbl[i].xc));
      check($sformatf("vec%0d_stall", i), int'(stl[0]), int'(tbl[i].xs));
      @(negedge clk);
    end

    // Bypass instance: zero-latency streaming
    do_reset();
    xfers = 0;
    for (int i = 1; i <= 8; i++) begin
      iv = 1'b1; idata = 8'(i); er = 1'b1;
      #1;
      check("byp_valid", int'(ev[1]), 1);
      check("byp_data", int'(ed[1]), i);
      check("byp_ready", int'(rdy[1]), 1);
      check("byp_count", int'(cnt[1]), 0);
      if (ev[1] && er) xfers++;
      @(negedge clk);
    end
    iv = 1'b0;
    check("byp_xfers", xfers, 8);

    // Stall counter saturation on the 3-bit instance
    do_reset();
    iv = 1'b1; idata = 8'd5; er = 1'b0;
    @(negedge clk);
    iv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("sat_stall%0d", i), int'(stl[2]), (i < 7) ? i : 7);
      @(negedge clk);
    end
    #1;
    check("sat_final", int'(stl[2]), 7);
    check("sat_valid", int'(ev[2]), 1);
    check("sat_data", int'(ed[2]), 5);
    check("nosat_stall", int'(stl[0]), 10);
    @(negedge clk);

    // Asynchronous reset with two words buffered
    do_reset();
    iv = 1'b1; idata = 8'd1; er = 1'b0;
    @(negedge clk);
    idata = 8'd2;
    @(negedge clk);
    iv = 1'b0;
    #1;
    check("arst_pre_count", int'(cnt[0]), 2);
    reset = 1'b0;
    #1;
    check("arst_valid", int'(ev[0]), 0);
    check("arst_ready", int'(rdy[0]), 1);
    check("arst_count", int'(cnt[0]), 0);
    check("arst_data", int'(ed[0]), 0);
    check("arst_stall", int'(stl[0]), 0);
    @(negedge clk);
    reset = 1'b1; iv = 1'b1; idata = 8'd42; er = 1'b1;
    @(negedge clk);
    iv = 1'b0;
    #1;
    check("arst_resume_valid", int'(ev[0]), 1);
    check("arst_resume_data", int'(ed[0]), 42);
    @(negedge clk);

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      fl = ($urandom_range(15) == 0);
      iv = ($urandom_range(9) < 7);
      idata = 8'($urandom);
      er = ($urandom_range(9) < 6);
      #1;
      for (int k = 0; k < 3; k++) model_step(k);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/skid_buffer_pipe.md
Name: skid_buffer_pipe

Overview:
Parametrised successor of the single-stage skid buffer, placed between a valid/ready producer ("i" side) and a valid/ready consumer ("e" side). It decouples backpressure timing. It supports two modes: a bypass skid and a fully registered stage with one cycle of latency. It adds a synchronous flush, an occupancy output and a saturating stall counter for performance monitoring.

Parameters:
DATA_W, 8, payload width in bits.
REG_OUT, 1, 0 = bypass skid (the output is combinational from the input when the skid is empty); 1 = fully registered output.
CNT_W, 16, width of the stall counter.

Ports:
clk  input  1  single clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset: asserting low clears all state immediately; deassertion is synchronised upstream.
flush_i  input  1  synchronous flush; drops all buffered data.
i_valid_i  input  1  producer valid.
i_data_i  input  DATA_W  producer data.
i_ready_o  output  1  buffer can accept; registered in both modes.
e_valid_o  output  1  consumer valid.
e_data_o  output  DATA_W  consumer data.
e_ready_i  input  1  consumer ready.
count_o  output  2  number of words held in the buffer (0..2).
stall_cnt_o  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Transfer rules: input side transfers when i_valid_i & i_ready_o; output side transfers when e_valid_o & e_ready_i.
- Data is never dropped or duplicated except by flush_i. Words leave in arrival order.
- Reset values while reset is low:
  - i_ready_o=1, e_valid_o=0, e_data_o=0, count_o=0, stall_cnt_o=0.
  - Skid and output registers are invalid and zeroed.
- Internal state: skid_valid/skid_data (both modes); out_valid/out_data (REG_OUT=1 only).
- i_ready_o = ~skid_valid, taken directly from the register.
- REG_OUT=0:
  - e_valid_o = skid_valid | i_valid_i.
  - e_data_o = skid_valid ? skid_data : i_data_i.
  - Skid loads i_data_i when the input transfers and e_ready_i=0.
  - Skid clears when e_ready_i=1.
  - Latency 0 cycles when the skid is empty.
- REG_OUT=1:
  - e_valid_o = out_valid; e_data_o = out_data.
  - Output register loads when ~out_valid | e_ready_i, with source priority: skid if skid_valid, else the input word if it transfers this cycle, else out_valid becomes 0.
  - Skid loads when the input transfers while out_valid=1 and e_ready_i=0.
  - Skid clears when it moves into the output register.
  - Latency 1 cycle, input to e_valid_o.
- Throughput: one word per cycle in both modes while e_ready_i=1.
- Full condition: skid_valid=1 gives i_ready_o=0 on the following cycle.
  - The word offered in the cycle the skid fills is captured, never lost.
- count_o:
  - REG_OUT=1: out_valid + skid_valid.
  - REG_OUT=0: skid_valid.
- stall_cnt_o:
  - Increments each cycle that e_valid_o=1 and e_ready_i=0.
  - Saturates at all-ones; no wrap.
  - Not cleared by flush_i; cleared only by reset.
- flush_i=1:
  - Next edge: skid_valid=0 and out_valid=0, so i_ready_o=1 and count_o=0 next cycle.
  - Any input word transferring in the flush cycle is discarded.
  - Any output transfer in the flush cycle still counts as delivered.
  - flush_i has priority over every load.
- Simultaneous fill and drain at count_o=2 with e_ready_i=1: the skid word moves to the output, and i_ready_o rises the next cycle.
- Reset asserted mid-transfer: buffered words are lost and outputs take their reset values asynchronously.

Test Plan:
1. REG_OUT=1: reset low 10 ns then high; drive i_valid_i=1 with data 90 then 255, e_ready_i=0 -> e_valid_o=1 with e_data_o=90 one cycle after acceptance; skid holds 255; count_o=2; i_ready_o=0; stall_cnt_o increments each cycle.
2. Continue scenario 1 and raise e_ready_i=1 -> e_data_o shows 90, then 255 on consecutive cycles; i_ready_o returns to 1; count_o reaches 0 after i_valid_i drops.
3. REG_OUT=0, e_ready_i=1, stream data 1..8 back-to-back -> e_data_o equals i_data_i in the same cycle; eight transfers in 8 cycles; count_o stays 0.
4. REG_OUT=1: fill to count_o=2, then pulse flush_i for 1 cycle while i_valid_i=1 with data 77 -> next cycle count_o=0, e_valid_o=0, i_ready_o=1; 77 never appears at the output.
5. CNT_W=3: hold e_valid_o=1 with e_ready_i=0 for 10 cycles -> stall_cnt_o saturates at 7 and stays there.
6. Assert reset low while count_o=2 -> e_valid_o=0, i_ready_o=1, count_o=0 without waiting for a clock edge; after release, normal operation resumes with data 42 -> e_data_o=42.
